rob_recovery_ctrl: RTL and testbench

ROB_RECOVERY_CTRL -- requirements
Module: rob_recovery_ctrl

---
 rtl/rob_recovery_ctrl.sv | 121 ++++++++++++
 tb/tb_rob_recovery_ctrl.sv | 205 ++++++++++++++++++++
 2 files changed

// File: rtl/rob_recovery_ctrl.sv
// ROB head mispredict recovery controller.
// Holds retire on a mispredicting head and pulses flush. It then drains
// in-flight FU work and redirects fetch to the recovery PC. Completed
// recoveries are counted per cause.
`ifndef PC_WIDTH
`define PC_WIDTH 32
`endif

module rob_recovery_ctrl #(
  parameter int PC_WIDTH  = `PC_WIDTH,
  parameter int DRAIN_MIN = 2,
  parameter int CNT_WIDTH = 16
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 head_valid,
  input  logic                 head_br_mispredict,
  input  logic                 head_ld_mispredict,
  input  logic [PC_WIDTH-1:0]  head_pc,
  input  logic [PC_WIDTH-1:0]  head_target_pc,
  input  logic                 fu_busy,
  input  logic                 redirect_ready,
  output logic                 retire_hold,
  output logic                 flush,
  output logic                 dispatch_stall,
  output logic                 redirect_valid,
  output logic [PC_WIDTH-1:0]  redirect_pc,
  output logic [CNT_WIDTH-1:0] br_flush_cnt,
  output logic [CNT_WIDTH-1:0] ld_flush_cnt
);

  typedef enum logic [1:0] {IDLE, FLUSH, DRAIN, REDIRECT} state_t;

  localparam logic [3:0] DRAIN_LAST = 4'(DRAIN_MIN - 1);
  localparam logic [3:0] DRAIN_SAT  = 4'(DRAIN_MIN);

  state_t              state;
  state_t              state_nxt;
  logic [3:0]          drain_cnt;
  logic                cause_br;
  logic [PC_WIDTH-1:0] saved_pc;
  logic                trigger;
  logic                accept;
  logic                drain_done;

  assign trigger    = head_valid & (head_br_mispredict | head_ld_mispredict);
  assign accept     = (state == REDIRECT) & redirect_ready;
  assign drain_done = (drain_cnt >= DRAIN_LAST) & ~fu_busy;

  // State register
  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  // Next-state logic
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:     if (trigger)    state_nxt = FLUSH;
      FLUSH:                    state_nxt = DRAIN;
      DRAIN:    if (drain_done) state_nxt = REDIRECT;
      REDIRECT: if (accept)     state_nxt = IDLE;
      default:                  state_nxt = IDLE;
    endcase
  end

  // Cause/PC capture on trigger and drain counter (loads 0 on DRAIN entry)
  always_ff @(posedge clk) begin
    if (rst) begin
      cause_br  <= 1'b0;
      saved_pc  <= '0;
      drain_cnt <= '0;
    end else begin
      if (state == IDLE && trigger) begin
        cause_br <= head_br_mispredict;
        saved_pc <= head_br_mispredict ? head_target_pc : head_pc;
      end
      if (state == FLUSH)
        drain_cnt <= '0;
      else if (state == DRAIN && drain_cnt < DRAIN_SAT)
        drain_cnt <= drain_cnt + 4'd1;
    end
  end

  // Saturating per-cause recovery counters, stepped on redirect acceptance
  always_ff @(posedge clk) begin
    if (rst) begin
      br_flush_cnt <= '0;
      ld_flush_cnt <= '0;
    end else if (accept) begin
      if (cause_br) begin
        if (br_flush_cnt != '1) br_flush_cnt <= br_flush_cnt + 1'b1;
      end else begin
        if (ld_flush_cnt != '1) ld_flush_cnt <= ld_flush_cnt + 1'b1;
      end
    end
  end

  // Output decode; redirect_valid depends only on state
  always_comb begin
    retire_hold    = 1'b1;
    dispatch_stall = 1'b1;
    flush          = 1'b0;
    redirect_valid = 1'b0;
    redirect_pc    = '0;
    case (state)
      IDLE: begin
        retire_hold    = trigger;
        dispatch_stall = 1'b0;
      end
      FLUSH: flush = 1'b1;
      REDIRECT: begin
        redirect_valid = 1'b1;
        redirect_pc    = saved_pc;
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_rob_recovery_ctrl.sv
// Directed bench for rob_recovery_ctrl. A second instance with 2-bit
// counters shares all inputs and exercises counter saturation.
`timescale 1ns/1ps
module tb_rob_recovery_ctrl;

  localparam int PCW       = 32;
  localparam int DRAIN_MIN = 2;

  logic           clk = 1'b0;
  logic           rst = 1'b1;
  logic           head_valid = 1'b0;
  logic           head_br = 1'b0;
  logic           head_ld = 1'b0;
  logic [PCW-1:0] head_pc = '0;
  logic [PCW-1:0] head_target_pc = '0;
  logic           fu_busy = 1'b0;
  logic           redirect_ready = 1'b0;

  logic           retire_hold, flush, dispatch_stall, redirect_valid;
  logic [PCW-1:0] redirect_pc;
  logic [15:0]    br_flush_cnt, ld_flush_cnt;

  logic           s_retire_hold, s_flush, s_dispatch_stall, s_redirect_valid;
  logic [PCW-1:0] s_redirect_pc;
  logic [1:0]     s_br_cnt, s_ld_cnt;

  int unsigned n_checks = 0;
  int unsigned n_fails  = 0;
  int unsigned exp_br   = 0;
  int unsigned exp_ld   = 0;

  always #5 clk = ~clk;

  rob_recovery_ctrl #(.PC_WIDTH(PCW), .DRAIN_MIN(DRAIN_MIN), .CNT_WIDTH(16)) dut (
    .clk(clk), .rst(rst),
    .head_valid(head_valid), .head_br_mispredict(head_br), .head_ld_mispredict(head_ld),
    .head_pc(head_pc), .head_target_pc(head_target_pc),
    .fu_busy(fu_busy), .redirect_ready(redirect_ready),
    .retire_hold(retire_hold), .flush(flush), .dispatch_stall(dispatch_stall),
    .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
    .br_flush_cnt(br_flush_cnt), .ld_flush_cnt(ld_flush_cnt)
  );

  rob_recovery_ctrl #(.PC_WIDTH(PCW), .DRAIN_MIN(DRAIN_MIN), .CNT_WIDTH(2)) dut_sat (
    .clk(clk), .rst(rst),
    .head_valid(head_valid), .head_br_mispredict(head_br), .head_ld_mispredict(head_ld),
    .head_pc(head_pc), .head_target_pc(head_target_pc),
    .fu_busy(fu_busy), .redirect_ready(redirect_ready),
    .retire_hold(s_retire_hold), .flush(s_flush), .dispatch_stall(s_dispatch_stall),
    .redirect_valid(s_redirect_valid), .redirect_pc(s_redirect_pc),
    .br_flush_cnt(s_br_cnt), .ld_flush_cnt(s_ld_cnt)
  );

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fails++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic check_counters(input string tag);
    int unsigned sat_br, sat_ld;
    sat_br = (exp_br > 3) ? 3 : exp_br;
    sat_ld = (exp_ld > 3) ? 3 : exp_ld;
    check_eq({tag, "_br_cnt"}, 32'(br_flush_cnt), exp_br);
    check_eq({tag, "_ld_cnt"}, 32'(ld_flush_cnt), exp_ld);
    check_eq({tag, "_sat_br_cnt"}, 32'(s_br_cnt), sat_br);
    check_eq({tag, "_sat_ld_cnt"}, 32'(s_ld_cnt), sat_ld);
  endtask

  task automatic check_idle_quiet(input string tag);
    check_eq({tag, "_retire_hold"}, 32'(retire_hold), 0);
    check_eq({tag, "_flush"}, 32'(flush), 0);
    check_eq({tag, "_dispatch_stall"}, 32'(dispatch_stall), 0);
    check_eq({tag, "_redirect_valid"}, 32'(redirect_valid), 0);
    check_eq({tag, "_redirect_pc"}, redirect_pc, 0);
  endtask

  // One full recovery. fu_busy is held for the first 'busy' DRAIN cycles,
  // redirect_ready is held low for 'stall' REDIRECT cycles.
  task automatic recover(input logic br, input logic ld, input logic [31:0] pc,
                         input logic [31:0] tgt, input int unsigned busy,
                         input int unsigned stall);
    logic [31:0] exp_pc;
    int unsigned drain;
    int unsigned exp_drain;
    bit          got;
    exp_pc    = br ? tgt : pc;
    exp_drain = (busy + 1 > DRAIN_MIN) ? busy + 1 : DRAIN_MIN;

    @(negedge clk);
    head_valid = 1'b1; head_br = br; head_ld = ld;
    head_pc = pc; head_target_pc = tgt;
    fu_busy = 1'b0; redirect_ready = 1'b0;
    #1;
    check_eq("trig_retire_hold", 32'(retire_hold), 1);
    check_eq("trig_dispatch_stall", 32'(dispatch_stall), 0);
    check_eq("trig_flush", 32'(flush), 0);

    @(posedge clk); #1;
    check_eq("flush_pulse", 32'(flush), 1);
    check_eq("flush_dispatch_stall", 32'(dispatch_stall), 1);
    check_eq("flush_retire_hold", 32'(retire_hold), 1);
    check_eq("flush_redirect_valid", 32'(redirect_valid), 0);
    check_eq("flush_redirect_pc", redirect_pc, 0);
    // Head stays mispredicting with different PCs: must not recapture.
    head_pc = ~pc; head_target_pc = ~tgt;

    drain = 0; got = 1'b0;
    for (int i = 0; i < 40 && !got; i++) begin
      @(posedge clk); #1;
      if (redirect_valid) got = 1'b1;
      else begin
        drain++;
        check_eq("drain_flush", 32'(flush), 0);
        check_eq("drain_retire_hold", 32'(retire_hold), 1);
        fu_busy = (drain <= busy);
      end
    end
    check_eq("drain_reached_redirect", 32'(got), 1);
    check_eq("drain_len", drain, exp_drain);
    fu_busy = 1'b0;

    for (int s = 0; s < int'(stall); s++) begin
      check_eq("bp_redirect_valid", 32'(redirect_valid), 1);
      check_eq("bp_redirect_pc", redirect_pc, exp_pc);
      check_eq("bp_dispatch_stall", 32'(dispatch_stall), 1);
      check_eq("bp_retire_hold", 32'(retire_hold), 1);
      @(posedge clk); #1;
    end
    check_eq("redir_valid", 32'(redirect_valid), 1);
    check_eq("redir_pc", redirect_pc, exp_pc);
    check_eq("redir_flush", 32'(flush), 0);
    redirect_ready = 1'b1;
    head_valid = 1'b0; head_br = 1'b0; head_ld = 1'b0;

    @(posedge clk); #1;
    redirect_ready = 1'b0;
    if (br) exp_br++; else exp_ld++;
    check_idle_quiet("post_accept");
    check_counters("post_accept");
  endtask

  initial begin
    // Reset held with a triggering head: stays IDLE, retire_hold follows trigger.
    head_valid = 1'b1; head_br = 1'b1;
    @(posedge clk); #1;
    @(posedge clk); #1;
    check_eq("rst_retire_hold_trig", 32'(retire_hold), 1);
    check_eq("rst_flush", 32'(flush), 0);
    check_eq("rst_dispatch_stall", 32'(dispatch_stall), 0);
    check_eq("rst_redirect_valid", 32'(redirect_valid), 0);
    check_eq("rst_redirect_pc", redirect_pc, 0);
    check_counters("rst");
    @(negedge clk);
    rst = 1'b0; head_valid = 1'b0; head_br = 1'b0;
    #1;
    check_idle_quiet("idle_none");
    // Mispredict flags without a valid head, and a valid clean head: no trigger.
    head_br = 1'b1; head_ld = 1'b1; #1;
    check_eq("invalid_head_retire_hold", 32'(retire_hold), 0);
    @(posedge clk); #1;
    check_eq("invalid_head_no_flush", 32'(flush), 0);
    head_br = 1'b0; head_ld = 1'b0; head_valid = 1'b1; #1;
    check_eq("clean_head_retire_hold", 32'(retire_hold), 0);
    @(posedge clk); #1;
    check_eq("clean_head_no_flush", 32'(flush), 0);
    head_valid = 1'b0;

    recover(1'b1, 1'b0, 32'h3FC, 32'h400, 0, 0);  // branch recovery
    recover(1'b1, 1'b1, 32'h100, 32'h200, 0, 0);  // both causes: branch wins
    recover(1'b0, 1'b1, 32'h080, 32'h084, 4, 0);  // load, busy units: DRAIN 5
    recover(1'b0, 1'b1, 32'h040, 32'h044, 0, 4);  // backpressure 4 cycles
    recover(1'b1, 1'b0, 32'h500, 32'h600, 1, 2);  // busy shorter than DRAIN_MIN

    // Reset on the 2nd REDIRECT cycle, with redirect_ready high on that edge.
    @(negedge clk);
    head_valid = 1'b1; head_br = 1'b1; head_target_pc = 32'h300;
    @(posedge clk); #1;
    head_valid = 1'b0; head_br = 1'b0;
    for (int i = 0; i < 40 && !redirect_valid; i++) begin
      @(posedge clk); #1;
    end
    check_eq("mid_redirect_entered", 32'(redirect_valid), 1);
    @(posedge clk); #1;
    check_eq("mid_redirect_2nd_valid", 32'(redirect_valid), 1);
    check_eq("mid_redirect_2nd_pc", redirect_pc, 32'h300);
    rst = 1'b1; redirect_ready = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0; redirect_ready = 1'b0;
    exp_br = 0; exp_ld = 0;
    check_idle_quiet("mid_redirect_rst");
    check_counters("mid_redirect_rst");

    // Four branch recoveries: 2-bit instance saturates at 3 and stays there.
    for (int k = 0; k < 4; k++)
      recover(1'b1, 1'b0, 32'h1000 + 32'(k), 32'h2000 + 32'(k * 4), 0, 0);
    check_eq("sat_br_held", 32'(s_br_cnt), 3);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

endmodule
